// File: rtl/bpuf_pkg.sv
// rtl/bpuf_pkg.sv - shared types, defaults and vote helper for the bistable-ring PUF evaluator
package bpuf_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXCITE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } bpuf_eval_state_t;

  localparam int unsigned DEF_N_CELLS       = 8;
  localparam int unsigned DEF_EXCITE_CYCLES = 4;
  localparam int unsigned DEF_SETTLE_CYCLES = 16;
  localparam int unsigned DEF_N_EVAL        = 5;

  // Strict majority; N_EVAL is odd so ties cannot occur.
  function automatic logic bpuf_majority(input int unsigned ones, input int unsigned n_eval);
    return ones > (n_eval / 2);
  endfunction

endpackage

// File: rtl/bpuf_sync.sv
// rtl/bpuf_sync.sv - parameterized-width two-flop synchronizer for the PUF cell outputs
module bpuf_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bpuf_eval_ctrl.sv
// rtl/bpuf_eval_ctrl.sv - excite/settle/sample sequencer with per-cell majority vote and response handshake
module bpuf_eval_ctrl
  import bpuf_pkg::*;
#(
  parameter int unsigned N_CELLS       = DEF_N_CELLS,
  parameter int unsigned EXCITE_CYCLES = DEF_EXCITE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned N_EVAL        = DEF_N_EVAL
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  output logic               busy,
  output logic               excite,
  input  logic [N_CELLS-1:0] q_in,
  output logic [N_CELLS-1:0] resp,
  output logic [N_CELLS-1:0] resp_unstable,
  output logic               resp_valid,
  input  logic               resp_ready
);

  localparam int unsigned PHASE_MAX = (EXCITE_CYCLES > SETTLE_CYCLES) ? EXCITE_CYCLES : SETTLE_CYCLES;
  localparam int unsigned PW        = $clog2(PHASE_MAX + 1);
  localparam int unsigned CW        = $clog2(N_EVAL + 1);

  localparam logic [PW-1:0] EXC_LAST = PW'(EXCITE_CYCLES - 1);
  localparam logic [PW-1:0] SET_LAST = PW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] N_EVAL_C = CW'(N_EVAL);

  bpuf_eval_state_t state_q, state_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic [CW-1:0]      round_q, round_d;
  logic [CW-1:0]      round_inc;
  logic [CW-1:0]      ones_q [N_CELLS];
  logic [CW-1:0]      ones_d [N_CELLS];
  logic [N_CELLS-1:0] resp_q, resp_d;
  logic [N_CELLS-1:0] unst_q, unst_d;
  logic               excite_q, excite_d;
  logic [N_CELLS-1:0] q_sync;

  bpuf_sync #(
    .WIDTH (N_CELLS)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (q_in),
    .q_o   (q_sync)
  );

  assign round_inc = round_q + CW'(1);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    round_d = round_q;
    ones_d  = ones_q;
    resp_d  = resp_q;
    unst_d  = unst_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          phase_d = '0;
          round_d = '0;
          for (int i = 0; i < int'(N_CELLS); i++) ones_d[i] = '0;
          state_d = ST_EXCITE;
        end
      end
      ST_EXCITE: begin
        if (phase_q == EXC_LAST) begin
          phase_d = '0;
          state_d = ST_SETTLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_SETTLE: begin
        if (phase_q == SET_LAST) begin
          phase_d = '0;
          state_d = ST_SAMPLE;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      ST_SAMPLE: begin
        for (int i = 0; i < int'(N_CELLS); i++) ones_d[i] = ones_q[i] + CW'(q_sync[i]);
        round_d = round_inc;
        if (round_inc < N_EVAL_C) begin
          state_d = ST_EXCITE;
        end else begin
          // Results are latched on the way into DONE so they include this final round.
          state_d = ST_DONE;
          for (int i = 0; i < int'(N_CELLS); i++) begin
            resp_d[i] = bpuf_majority(32'(ones_d[i]), N_EVAL);
            unst_d[i] = (ones_d[i] != '0) && (ones_d[i] != N_EVAL_C);
          end
        end
      end
      ST_DONE: begin
        if (resp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    excite_d = (state_d == ST_EXCITE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      phase_q  <= '0;
      round_q  <= '0;
      resp_q   <= '0;
      unst_q   <= '0;
      excite_q <= 1'b0;
      for (int i = 0; i < int'(N_CELLS); i++) ones_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      round_q  <= round_d;
      resp_q   <= resp_d;
      unst_q   <= unst_d;
      excite_q <= excite_d;
      ones_q   <= ones_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign resp_valid    = (state_q == ST_DONE);
  assign excite        = excite_q;
  assign resp          = resp_q;
  assign resp_unstable = unst_q;

endmodule

// File: tb/tb_bpuf_eval_ctrl.sv
// tb/tb_bpuf_eval_ctrl.sv - directed self-checking bench for bpuf_eval_ctrl with a cycle-level reference model
module tb_bpuf_eval_ctrl;

  localparam int NC = 8;
  localparam int E  = 4;
  localparam int S  = 16;
  localparam int NE = 5;
  localparam int RL = E + S + 1;
  localparam int TV = NE * RL + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [NC-1:0] q_in;
  logic          resp_ready;
  logic          busy;
  logic          excite;
  logic [NC-1:0] resp;
  logic [NC-1:0] resp_unstable;
  logic          resp_valid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bpuf_eval_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .busy          (busy),
    .excite        (excite),
    .q_in          (q_in),
    .resp          (resp),
    .resp_unstable (resp_unstable),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles counted from the accepted start; votes taken from q_in two cycles before each sample.
  bit            cmp_en  = 1'b0;
  bit            m_busy  = 1'b0;
  bit            m_valid = 1'b0;
  int            m_k     = 0;
  int            votes [NC];
  logic [NC-1:0] m_resp  = '0;
  logic [NC-1:0] m_unst  = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_busy = 0; m_valid = 0; m_k = 0; m_resp = '0; m_unst = '0;
      for (int i = 0; i < NC; i++) votes[i] = 0;
      cmp_en = 1'b1;
    end else if (m_valid) begin
      if (resp_ready) begin
        m_valid = 0;
        m_busy  = 0;
      end
    end else if (m_busy) begin
      if (m_k % RL == RL - 2)
        for (int i = 0; i < NC; i++) votes[i] += int'(q_in[i]);
      if (m_k == TV - 1) begin
        for (int i = 0; i < NC; i++) begin
          m_resp[i] = (votes[i] > NE / 2);
          m_unst[i] = (votes[i] != 0) && (votes[i] != NE);
        end
        m_valid = 1;
      end
      m_k++;
    end else if (start) begin
      m_busy = 1;
      m_k    = 1;
      for (int i = 0; i < NC; i++) votes[i] = 0;
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("excite", excite, (m_busy && !m_valid && ((m_k - 1) % RL) < E));
      check("busy", busy, m_busy);
      check("resp_valid", resp_valid, m_valid);
      check("resp", resp, m_resp);
      check("resp_unstable", resp_unstable, m_unst);
    end
  end

  logic [NC-1:0] pat [NE];
  int abort_k = 0;
  int xs1     = 0;
  int xs2     = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic run_eval(input logic [NC-1:0] exp_resp, input logic [NC-1:0] exp_unst);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k < TV; k++) begin
      q_in  = pat[(k - 1) / RL];
      start = (k == xs1) || (k == xs2);
      if (k == 1) check("excite_rise", excite, 1);
      if (k == TV - 1) check("valid_early", resp_valid, 0);
      if (k == abort_k) begin
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        start = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_excite", excite, 0);
        check("abort_valid", resp_valid, 0);
        return;
      end
      cyc();
    end
    start = 1'b0;
    check("valid_at_t106", resp_valid, 1);
    check("resp_lit", resp, exp_resp);
    check("unst_lit", resp_unstable, exp_unst);
  endtask

  initial begin
    rst_n      = 1'b0;
    start      = 1'($urandom);
    q_in       = NC'($urandom);
    resp_ready = 1'($urandom);
    for (int c = 0; c < 3; c++) begin
      cyc();
      start      = 1'($urandom);
      q_in       = NC'($urandom);
      resp_ready = 1'($urandom);
    end
    check("rst_excite", excite, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", resp_valid, 0);
    check("rst_resp", resp, 8'h00);
    check("rst_unst", resp_unstable, 8'h00);

    rst_n = 1'b1; start = 1'b0; q_in = '0; resp_ready = 1'b1;
    cyc();

    // Stable cells, consumer always ready: one-cycle valid pulse.
    for (int r = 0; r < NE; r++) pat[r] = 8'hA5;
    run_eval(8'hA5, 8'h00);
    cyc();
    check("pulse_valid_drop", resp_valid, 0);
    check("pulse_busy_drop", busy, 0);
    check("pulse_resp_hold", resp, 8'hA5);

    // Noisy cells 0 and 1.
    pat[0] = 8'h01; pat[1] = 8'h00; pat[2] = 8'h03; pat[3] = 8'h00; pat[4] = 8'h01;
    run_eval(8'h01, 8'h03);
    cyc();

    // Backpressure with an ignored start in DONE.
    resp_ready = 1'b0;
    pat[0] = 8'h5A; pat[1] = 8'h5A; pat[2] = 8'h5B; pat[3] = 8'h5A; pat[4] = 8'h5A;
    run_eval(8'h5A, 8'h01);
    for (int c = 0; c < 10; c++) begin
      start = (c == 5);
      cyc();
      check("bp_valid_hold", resp_valid, 1);
      check("bp_resp_hold", resp, 8'h5A);
    end
    start      = 1'b0;
    resp_ready = 1'b1;
    cyc();
    check("bp_busy_drop", busy, 0);
    check("bp_valid_drop", resp_valid, 0);
    cyc();
    check("bp_no_queued_start", busy, 0);

    // Reset during round 3 SETTLE, then a fresh full evaluation.
    for (int r = 0; r < NE; r++) pat[r] = 8'hFF;
    abort_k = 2 * RL + E + 4;
    run_eval(8'h00, 8'h00);
    abort_k = 0;
    check("abort_resp_cleared", resp, 8'h00);
    cyc();
    for (int r = 0; r < NE; r++) pat[r] = 8'h3C;
    run_eval(8'h3C, 8'h00);
    cyc();

    // Start pulses while busy in EXCITE and SAMPLE are ignored.
    for (int r = 0; r < NE; r++) pat[r] = 8'hC3;
    pat[2] = 8'hC2;
    xs1 = 2;
    xs2 = RL;
    run_eval(8'hC3, 8'h01);
    xs1 = 0;
    xs2 = 0;
    for (int c = 0; c < 30; c++) cyc();
    check("busy_start_single", busy, 0);
    check("busy_start_novalid", resp_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/bpuf_eval_ctrl.md
# bpuf_eval_ctrl

Evaluation controller that sits directly around an array of bistable-ring PUF cells. It drives their shared `excite` line and samples their `Q` outputs. For each challenge it runs `N_EVAL` excite/settle/sample rounds and majority-votes each cell's response. It then presents an `N_CELLS`-bit response and a per-bit instability mask to the downstream consumer over a valid/ready handshake.

## Interface
Parameters:
- `N_CELLS`, default 8: number of PUF cells observed.
- `EXCITE_CYCLES`, default 4: cycles `excite` is held high per round; must be ≥1.
- `SETTLE_CYCLES`, default 16: cycles after excite release before sampling; must be ≥2 to cover synchronizer latency.
- `N_EVAL`, default 5: rounds per response; must be odd and ≥1.

Ports:
- `clk` in 1: single clock, shared with the PUF cells.
- `rst_n` in 1: reset, **synchronous, active-low**.
- `start` in 1: single-cycle request; honoured only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `excite` out 1: registered; drives the `excite` input of every cell.
- `q_in` in `N_CELLS`: cell `Q` outputs, asynchronous to logic.
- `resp` out `N_CELLS`: majority-voted response.
- `resp_unstable` out `N_CELLS`: set for each bit whose votes were not unanimous.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: consumer accepts.

## Operation
- `q_in` passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, EXCITE, SETTLE, SAMPLE, DONE.
- **IDLE**
  - `excite`=0.
  - On `start`=1: clear the per-cell ones-counters and the round counter, then go to EXCITE.
- **EXCITE**
  - `excite`=1 for exactly `EXCITE_CYCLES` cycles, then go to SETTLE.
- **SETTLE**
  - `excite`=0 for `SETTLE_CYCLES` cycles, then go to SAMPLE.
- **SAMPLE** (one cycle)
  - Each cell's ones-counter increments if its synchronized `q_in` bit is 1.
  - The round counter increments.
  - If the round count is still below `N_EVAL`, go to EXCITE; otherwise go to DONE.
- **DONE**
  - On entry, register `resp[i] = ones[i] > N_EVAL/2`.
  - On entry, register `resp_unstable[i] = (ones[i] != 0) && (ones[i] != N_EVAL)`.
  - `resp_valid`=1, with `resp` and `resp_unstable` held constant.
  - On `resp_valid && resp_ready`, go to IDLE.
- Width rules:
  - Ones-counters are `$clog2(N_EVAL+1)` bits and cannot overflow.
  - The phase counter is `$clog2(max(EXCITE_CYCLES, SETTLE_CYCLES)+1)` bits.
  - The round counter is `$clog2(N_EVAL+1)` bits.
- `start` while `busy`=1, including in DONE, is ignored with no queuing.
- `resp_ready` outside DONE has no effect.

## Timing
- Reset values:
  - FSM in IDLE.
  - `excite`, `busy`, `resp_valid` all 0.
  - `resp` and `resp_unstable` all zeros.
  - All counters 0.
  - Synchronizer flops 0.
- `rst_n` low in any state aborts the evaluation: next cycle is IDLE with all outputs at reset values and partial votes discarded.
- With `start` accepted at cycle t:
  - `excite` rises at t+1.
  - One round lasts `EXCITE_CYCLES + SETTLE_CYCLES + 1` cycles.
  - `resp_valid` rises at t + `N_EVAL`·(E+S+1) + 1. Defaults give t+106.
- Sampled data was present on `q_in` at least 2 cycles before SAMPLE; SETTLE ≥2 guarantees this.
- Handshake completes in the cycle `resp_valid && resp_ready`:
  - `resp_valid` and `busy` drop the next cycle.
  - `resp` and `resp_unstable` retain their values until the next DONE entry.
  - The earliest new `start` is honoured in the cycle after the handshake.
- `resp_ready` held high before DONE gives a one-cycle `resp_valid` pulse.

## Structure
- Shared package `bpuf_pkg` holds:
  - the FSM state enum `bpuf_eval_state_t`;
  - default parameter constants;
  - the majority threshold helper.
- Sub-module `bpuf_sync`: parameterized-width 2-flop synchronizer for `q_in`. It uses the same `clk` and `rst_n`.
- Remaining logic is a single module: FSM, phase and round counters, ones-counter array, result registers.

## Test plan
All scenarios use defaults: `N_CELLS`=8, E=4, S=16, `N_EVAL`=5. The bench models the cells.
1. Reset: `rst_n`=0 for 3 cycles with random inputs → `excite`=0, `busy`=0, `resp_valid`=0, `resp`=0x00, `resp_unstable`=0x00.
2. Stable response: `start` at t with `q_in`=0xA5 constant and `resp_ready`=1 →
   - `excite` high for cycles t+1..t+4 of each 21-cycle round (5 pulses);
   - `resp_valid` at t+106 with `resp`=0xA5 and `resp_unstable`=0x00.
3. Noisy bits: cell0 reads 1,0,1,0,1 and cell1 reads 0,0,1,0,0 across rounds, others 0 → `resp`=0x01, `resp_unstable`=0x03.
4. Backpressure: `resp_ready`=0 for 10 cycles after valid, plus a `start` pulse during DONE →
   - `resp_valid` held and `resp` stable;
   - the `start` is ignored;
   - after `resp_ready`=1, IDLE and `busy`=0 the next cycle.
5. Reset mid-run: `rst_n`=0 during round 3 SETTLE → IDLE and `excite`=0 next cycle. A fresh `start` then yields a full 5-round result at +106 unaffected by the aborted votes.
6. Busy start: `start` pulses during EXCITE and SAMPLE → ignored. Exactly one response is produced, at the original t+106.
